// File: rtl/flopr_pkg.sv
// Shared constants for the flopr register pipeline.
package flopr_pkg;

  localparam int FLOPR_DEFAULT_WIDTH = 8;
  localparam int FLOPR_MAX_WIDTH     = 64;
  localparam int FLOPR_MAX_STAGES    = 16;

endpackage

// File: rtl/flopr_stage.sv
// One WIDTH-bit register with asynchronous active-low reset.
// The stage enable exists only when FLOPR_ENABLE_EN is defined.
module flopr_stage
  import flopr_pkg::*;
#(
  parameter int               WIDTH       = FLOPR_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
`ifdef FLOPR_ENABLE_EN
  input  logic             en,
`endif
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

`ifdef FLOPR_ENABLE_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= RESET_VALUE;
    end else if (en) begin
      q <= d;
    end
  end
`else
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= RESET_VALUE;
    end else begin
      q <= d;
    end
  end
`endif

endmodule

// File: rtl/flopr.sv
// Cascade of STAGES resettable registers; q is d delayed by STAGES edges.
// Optional feature macro: FLOPR_ENABLE_EN adds a shared active-high stage enable.
module flopr
  import flopr_pkg::*;
#(
  parameter int               WIDTH       = FLOPR_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               STAGES      = 1
) (
  input  logic             clk,
  input  logic             reset,
`ifdef FLOPR_ENABLE_EN
  input  logic             en,
`endif
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (WIDTH < 1 || WIDTH > FLOPR_MAX_WIDTH) begin : g_bad_width
    $error("flopr: WIDTH=%0d is outside the legal range 1..%0d", WIDTH, FLOPR_MAX_WIDTH);
  end

  if (STAGES < 1 || STAGES > FLOPR_MAX_STAGES) begin : g_bad_stages
    $error("flopr: STAGES=%0d is outside the legal range 1..%0d", STAGES, FLOPR_MAX_STAGES);
  end

  logic [WIDTH-1:0] stage_q [STAGES];

  // Stage 0 captures d; every later stage captures its predecessor.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] stage_d;

    if (k == 0) begin : g_first
      assign stage_d = d;
    end else begin : g_next
      assign stage_d = stage_q[k-1];
    end

    flopr_stage #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) u_stage (
      .clk   (clk),
      .reset (reset),
`ifdef FLOPR_ENABLE_EN
      .en    (en),
`endif
      .d     (stage_d),
      .q     (stage_q[k])
    );
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: tb/tb_flopr.sv
// Scoreboard bench for flopr: a one-stage instance and a three-stage instance
// with a non-zero reset value share clk and reset.
module tb_flopr;

  localparam logic [7:0] RV3 = 8'h5A;

  typedef struct {
    string      name;
    int         unit;
    logic [7:0] exp;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [7:0] d1, d3;
  logic [7:0] q1, q3;
`ifdef FLOPR_ENABLE_EN
  logic       en;
`endif

  exp_t exp_q[$];
  event check_ev;
  int   tests_run    = 0;
  int   tests_failed = 0;

  flopr #(.WIDTH(8), .RESET_VALUE(8'h00), .STAGES(1)) dut1 (
    .clk   (clk),
    .reset (reset),
`ifdef FLOPR_ENABLE_EN
    .en    (en),
`endif
    .d     (d1),
    .q     (q1)
  );

  flopr #(.WIDTH(8), .RESET_VALUE(RV3), .STAGES(3)) dut3 (
    .clk   (clk),
    .reset (reset),
`ifdef FLOPR_ENABLE_EN
    .en    (en),
`endif
    .d     (d3),
    .q     (q3)
  );

  // Monitor: drains the expectation queue each time a sample point is announced.
  initial begin
    forever begin
      @(check_ev);
      while (exp_q.size() > 0) begin
        exp_t e;
        logic [7:0] act;
        e = exp_q.pop_front();
        act = (e.unit == 3) ? q3 : q1;
        tests_run++;
        if (act !== e.exp) begin
          tests_failed++;
          $display("[TB] FAIL %s: q=%02h expected %02h", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic tick();
    clk = 1'b1;
    #5;
    clk = 1'b0;
    #5;
  endtask

  task automatic expect_q(input int unit, input string name, input logic [7:0] exp);
    exp_t e;
    e.name = name;
    e.unit = unit;
    e.exp  = exp;
    exp_q.push_back(e);
  endtask

  task automatic check_output();
    -> check_ev;
    #1;
  endtask

  task automatic apply_stimulus(input logic [7:0] v1, input logic [7:0] v3);
    d1 = v1;
    d3 = v3;
    tick();
  endtask

  logic [7:0] stream_d   [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h44, 8'h44};
  logic [7:0] stream_exp [6] = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};

  initial begin
    clk   = 1'b0;
    reset = 1'b1;
    d1    = 8'hA5;
    d3    = 8'h00;
`ifdef FLOPR_ENABLE_EN
    en    = 1'b1;
`endif
    #1;

    // Asynchronous reset with no clock edge, then release with no edge.
    reset = 1'b0;
    #5;
    expect_q(1, "reset_async_q1", 8'h00);
    expect_q(3, "reset_async_q3", RV3);
    check_output();
    reset = 1'b1;
    #5;
    expect_q(1, "reset_release_q1", 8'h00);
    expect_q(3, "reset_release_q3", RV3);
    check_output();

    // Single-stage capture and hold; three-stage reset value drains out.
    apply_stimulus(8'h3C, 8'h00);
    expect_q(1, "capture_3c", 8'h3C);
    expect_q(3, "drain_edge1", RV3);
    check_output();
    apply_stimulus(8'h3C, 8'h00);
    expect_q(1, "hold_3c", 8'h3C);
    expect_q(3, "drain_edge2", RV3);
    check_output();

    // d moving between edges must not reach q.
    d1 = 8'h99;
    #2;
    expect_q(1, "d_between_edges", 8'h3C);
    check_output();
    tick();
    expect_q(1, "capture_99", 8'h99);
    expect_q(3, "drain_edge3", 8'h00);
    check_output();

    // Streaming: three-stage latency, one-stage follows d each edge.
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(stream_d[i], stream_d[i]);
      expect_q(1, $sformatf("stream1_%0d", i), stream_d[i]);
      expect_q(3, $sformatf("stream3_%0d", i), stream_exp[i]);
      check_output();
    end

    // Reset mid-stream discards in-flight data immediately.
    apply_stimulus(8'h55, 8'h55);
    apply_stimulus(8'h66, 8'h66);
    expect_q(3, "inflight_q3", 8'h44);
    check_output();
    reset = 1'b0;
    #1;
    expect_q(1, "midstream_reset_q1", 8'h00);
    expect_q(3, "midstream_reset_q3", RV3);
    check_output();
    apply_stimulus(8'hFF, 8'hFF);
    expect_q(1, "ignore_clk_in_reset_q1", 8'h00);
    expect_q(3, "ignore_clk_in_reset_q3", RV3);
    check_output();
    reset = 1'b1;
    #5;
    apply_stimulus(8'hAB, 8'hAB);
    expect_q(3, "post_reset_edge1", RV3);
    check_output();
    apply_stimulus(8'hAB, 8'hAB);
    apply_stimulus(8'hAB, 8'hAB);
    expect_q(3, "post_reset_edge3", 8'hAB);
    check_output();

    // Reset falling together with a rising edge: reset wins.
    d1 = 8'h77;
    d3 = 8'h77;
    #5;
    reset = 1'b0;
    clk   = 1'b1;
    #5;
    clk   = 1'b0;
    #5;
    expect_q(1, "reset_vs_edge_q1", 8'h00);
    expect_q(3, "reset_vs_edge_q3", RV3);
    check_output();
    reset = 1'b1;
    #5;

`ifdef FLOPR_ENABLE_EN
    // Enable low freezes every stage; raising it resumes capture.
    apply_stimulus(8'h3C, 8'h3C);
    expect_q(1, "en_preload", 8'h3C);
    check_output();
    en = 1'b0;
    apply_stimulus(8'hFF, 8'hFF);
    apply_stimulus(8'hFF, 8'hFF);
    expect_q(1, "en_low_hold_q1", 8'h3C);
    expect_q(3, "en_low_hold_q3", RV3);
    check_output();
    en = 1'b1;
    apply_stimulus(8'hFF, 8'hFF);
    expect_q(1, "en_high_capture", 8'hFF);
    check_output();
`endif

    #5;
    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL scoreboard_drain: pending=%0d expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/flopr.md
FLOPR -- requirements
Module: flopr

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits; legal range 1..64.
REQ-002 Parameter RESET_VALUE, default all-zeros, value loaded into every register stage on reset; WIDTH bits.
REQ-003 Parameter STAGES, default 1, number of cascaded register stages, which equals the latency in cycles; legal range 1..16.
REQ-004 Port clk, input, 1 bit; the only clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1 bit; asynchronous, active-low reset.
REQ-006 Port d, input, WIDTH bits; data captured at the first stage.
REQ-007 Port q, output, WIDTH bits; the last stage's register, driven directly by a flop with no combinational path from d.
REQ-008 Port en, input, 1 bit, active-high stage enable; present only when FLOPR_ENABLE_EN is defined (REQ-018).

Function
REQ-009 On each rising clk edge with reset high, stage 0 SHALL load d and stage k SHALL load stage k-1, for k = 1..STAGES-1.
REQ-010 q SHALL equal the value of d sampled STAGES rising edges earlier; with STAGES=1, q updates on the first rising edge after d changes.
REQ-011 Between rising edges, q SHALL hold its value; a falling edge or clk held high has no effect.
REQ-012 Changes on d between edges SHALL NOT affect q until the next rising edge.
REQ-013 Width rule: q is bit-exact to d; no sign extension, truncation or arithmetic.

Reset
REQ-014 When reset goes low, all stages and q SHALL take RESET_VALUE immediately, without waiting for a clock edge.
REQ-015 While reset is low, the stages SHALL ignore clk, d and en.
REQ-016 After reset rises, q SHALL stay at RESET_VALUE until the first rising clk edge with reset high; with STAGES>1, RESET_VALUE drains out over STAGES edges.
REQ-017 If reset is low at a rising edge, reset wins; reset asserted mid-pipeline discards all in-flight data.

Configuration
REQ-018 With FLOPR_ENABLE_EN defined, port en exists, and with en low every stage holds its value on rising edges; reset still acts per REQ-014.
REQ-019 Without FLOPR_ENABLE_EN, port en is absent and every stage loads on every rising edge.

Structure
REQ-020 Package flopr_pkg SHALL hold the constants FLOPR_DEFAULT_WIDTH (8), FLOPR_MAX_STAGES (16) and FLOPR_MAX_WIDTH (64).
REQ-021 A sub-module flopr_stage SHALL implement one WIDTH-bit async-reset register (with optional enable); flopr instantiates STAGES copies in a generate loop.
REQ-022 Elaboration SHALL fail with a message when WIDTH or STAGES is outside its legal range.

Verification
REQ-023 WIDTH=8, STAGES=1: d=A5, reset low, no clock edge, after 5 time units -> q=00.
REQ-024 After that, reset high with no clock edge, after 5 time units -> q remains 00.
REQ-025 d=3C, one rising edge then falling edge -> q=3C; a further rising edge and then falling edge with d unchanged -> q stays 3C.
REQ-026 STAGES=3, apply d=11,22,33,44 on consecutive edges -> q shows 11 on the third edge, then 22, 33 and 44 on the following edges; reset low mid-stream -> q=RESET_VALUE at once.
REQ-027 FLOPR_ENABLE_EN defined, q=3C, en=0, d=FF, two edges -> q=3C; then en=1, one edge -> q=FF.
REQ-028 reset low coincident with a rising edge while d=77 -> q=RESET_VALUE, not 77.
